ysyx_23060180_mem_responder: RTL
================================

Name: ysyx_23060180_mem_responder

Overview:
Memory-side responder for the core's simple memory port. It answers `mem_rd`/`mem_raddr` with `mem_rdata` after a fixed, parameterised latency, and it accepts byte-masked single-cycle writes for the store path. Backing store is an internal word-addressed array located at `BASE_ADDR`. The block sits beside the CPU core in the top-level `npc` and replaces the testbench-driven memory model.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit words; must be a power of two.
- READ_LATENCY, 1, cycles from `mem_rd` sample to data valid; legal range 1..4. The core requires 1.
- OOR_RDATA, 32'h0000_0000, data returned for an out-of-range read.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rd  in  1  read request, sampled every rising edge.
- mem_raddr  in  32  read byte address; bits [1:0] ignored.
- mem_rdata  out  32  read data, registered.
- mem_rvalid  out  1  one-cycle pulse; `mem_rdata` is valid in this cycle.
- mem_wr  in  1  write request, sampled every rising edge.
- mem_waddr  in  32  write byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wmask  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- mem_err  out  1  one-cycle pulse marking an out-of-range access (read response or write).
- rd_count  out  32  number of accepted reads; wraps modulo 2^32.
- wr_count  out  32  number of accepted writes with a nonzero mask; wraps.

Behaviour:
- Reset, applied asynchronously while `rst`=1:
  - `mem_rdata`=0, `mem_rvalid`=0, `mem_err`=0, `rd_count`=0, `wr_count`=0.
  - Read pipeline valid bits are cleared.
  - Array contents are not reset.
- Address decode: `idx = (addr - BASE_ADDR) >> 2`, computed with 32-bit unsigned arithmetic. An access is in range iff `addr - BASE_ADDR < DEPTH_WORDS*4`. Addresses below `BASE_ADDR` wrap to large values and are therefore out of range.
- Read path:
  - `mem_rd`=1 at edge N captures `idx` and the in-range flag into pipeline stage 1.
  - The array is read in the final stage.
  - `mem_rdata` and `mem_rvalid` are presented in the cycle after edge N+READ_LATENCY-1. With latency 1 this is the cycle following the request, which is where the core samples.
- Read throughput: one request per cycle, fully pipelined. Responses come back in request order, and no request is dropped or merged.
- `mem_rdata` holds its last value while `mem_rvalid`=0. The core relies on this hold.
- Out-of-range read: the response carries `OOR_RDATA`, and `mem_err` pulses in the same cycle as `mem_rvalid`.
- Write path:
  - `mem_wr`=1 at an edge with an in-range address updates only the byte lanes selected by `mem_wmask`, at that edge. Latency is 0 and there is no response.
  - `mem_wmask`=0 is a no-op: no counter increment, no error.
  - Out-of-range write: the array is untouched, `mem_err` pulses the next cycle, and `wr_count` does not increment.
- Read and write to the same word at the same edge (read-before-write): the read returns the pre-write data. A read issued at a later edge sees the new data.
- Both an out-of-range write and an out-of-range read response in the same cycle produce a single `mem_err` pulse.
- `rd_count` increments on every edge where `mem_rd`=1, including out-of-range reads.
- Reset asserted mid-operation: in-flight reads are discarded and no `mem_rvalid` appears after reset release. Writes already committed remain in the array.
- No X propagation: an unwritten word reads as the simulator's initial value. The team's ELF preload uses `$readmemh` under a `ifdef MEM_INIT_FILE` guard.

Decomposition:
- Shared package `ysyx_23060180_pkg`:
  - `XLEN`=32
  - `RESET_PC`=32'h8000_0000 (the default for `BASE_ADDR`)
  - the byte-mask typedef `wmask_t` (logic [3:0])
  - a `word_t` typedef
- One sub-module, `ysyx_23060180_mem_rpipe`: a parameterised READ_LATENCY-1 stage valid/idx/oor shift pipe with asynchronous reset of the valid bits. The top instantiates the pipe, the array and the counters.

Test Plan:
- Reset then single read: write 32'h1234_5678 @ 32'h8000_0010 with mask 4'hF, then read 32'h8000_0010 → `mem_rvalid` the next cycle, `mem_rdata`=32'h1234_5678, `mem_err`=0, `rd_count`=1.
- Byte mask: the word holds 32'h1122_3344; write 32'hAABB_CCDD with mask 4'b0101 → a following read returns 32'h11BB_33DD; `wr_count` increments by 1.
- Back-to-back reads at 32'h8000_0000, 32'h8000_0004, 32'h8000_0008 on 3 consecutive cycles → 3 consecutive `mem_rvalid` pulses, in order, with matching data; `mem_rdata` holds the last word afterwards.
- Same-edge read and write to 32'h8000_0020 (old 32'h0000_0001, new 32'h0000_0002) → the read returns 32'h0000_0001; a read on the next edge returns 32'h0000_0002.
- Out of range: read 32'h7FFF_FFFC and read `BASE_ADDR + DEPTH_WORDS*4` → each returns `OOR_RDATA` with `mem_err`=1. Write 32'h0000_0000 → array unchanged, `mem_err` pulses once, `wr_count` unchanged.
- With READ_LATENCY=3: issue a read, then assert `rst` for 1 cycle while it is in flight → no `mem_rvalid` after release, all outputs 0, previously written data still readable.

Source files
------------

// File: rtl/ysyx_23060180_pkg.sv
// Shared types and constants for the ysyx_23060180 core and its memory-side blocks.
package ysyx_23060180_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [3:0]      wmask_t;
endpackage

// File: rtl/ysyx_23060180_mem_rpipe.sv
// Read-request delay line: carries valid/idx/oor through STAGES registers.
// Only the valid bits are reset; the payload simply follows them.
module ysyx_23060180_mem_rpipe #(
    parameter int STAGES = 0,
    parameter int IDX_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_oor,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_oor
);
    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_vld = in_vld;
            assign out_idx = in_idx;
            assign out_oor = in_oor;
        end else begin : g_pipe
            logic [STAGES:1]            vld_pipe;
            logic [STAGES:1][IDX_W-1:0] idx_pipe;
            logic [STAGES:1]            oor_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[1] <= in_vld;
                    for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            always_ff @(posedge clk) begin
                idx_pipe[1] <= in_idx;
                oor_pipe[1] <= in_oor;
                for (int i = 2; i <= STAGES; i++) begin
                    idx_pipe[i] <= idx_pipe[i-1];
                    oor_pipe[i] <= oor_pipe[i-1];
                end
            end

            assign out_vld = vld_pipe[STAGES];
            assign out_idx = idx_pipe[STAGES];
            assign out_oor = oor_pipe[STAGES];
        end
    endgenerate
endmodule

// File: rtl/ysyx_23060180_mem_responder.sv
// Memory responder beside the npc core: fixed-latency pipelined reads,
// byte-masked zero-latency writes, out-of-range flagging and access counters.
module ysyx_23060180_mem_responder
    import ysyx_23060180_pkg::*;
#(
    parameter word_t BASE_ADDR    = RESET_PC,
    parameter int    DEPTH_WORDS  = 4096,
    parameter int    READ_LATENCY = 1,
    parameter word_t OOR_RDATA    = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   mem_rd,
    input  word_t  mem_raddr,
    output word_t  mem_rdata,
    output logic   mem_rvalid,
    input  logic   mem_wr,
    input  word_t  mem_waddr,
    input  word_t  mem_wdata,
    input  wmask_t mem_wmask,
    output logic   mem_err,
    output word_t  rd_count,
    output word_t  wr_count
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // 33-bit span so the range compare cannot overflow for large depths
    localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH_WORDS) << 2;

    word_t r_off, w_off;
    logic  r_in, w_in;
    logic [IDX_W-1:0] r_idx, w_idx;

    assign r_off = mem_raddr - BASE_ADDR;
    assign w_off = mem_waddr - BASE_ADDR;
    assign r_in  = {1'b0, r_off} < SPAN;
    assign w_in  = {1'b0, w_off} < SPAN;
    assign r_idx = r_off[IDX_W+1:2];
    assign w_idx = w_off[IDX_W+1:2];

    logic             p_vld, p_oor;
    logic [IDX_W-1:0] p_idx;

    ysyx_23060180_mem_rpipe #(
        .STAGES(READ_LATENCY - 1),
        .IDX_W (IDX_W)
    ) u_rpipe (
        .clk    (clk),
        .rst    (rst),
        .in_vld (mem_rd),
        .in_idx (r_idx),
        .in_oor (!r_in),
        .out_vld(p_vld),
        .out_idx(p_idx),
        .out_oor(p_oor)
    );

    word_t mem [DEPTH_WORDS];

    logic wr_fire, wr_oor;
    assign wr_fire = mem_wr && (mem_wmask != 4'b0000);
    assign wr_oor  = wr_fire && !w_in;

    // Array is never reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_fire && w_in) begin
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) mem[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata  <= '0;
            mem_rvalid <= 1'b0;
            mem_err    <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            mem_rvalid <= p_vld;
            if (p_vld) mem_rdata <= p_oor ? OOR_RDATA : mem[p_idx];
            mem_err <= (p_vld && p_oor) || wr_oor;
            if (mem_rd) rd_count <= rd_count + 32'd1;
            if (wr_fire && w_in) wr_count <= wr_count + 32'd1;
        end
    end
endmodule
